// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants for the IF-stage PC owner: reset PC, step size, FSM encodings.
// Alignment checking is selected at build time by PC_ALIGN_CHECK_EN (see pc_fetch_ctrl.sv).
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;
  localparam int unsigned PKG_PC_STEP  = 4;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_HOLD_PEND = 2'd2;

  // Word-align a redirect target by clearing its byte-offset bits.
  function automatic logic [31:0] word_align(input logic [31:0] t);
    return t & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Next-PC interface between the redirect/stall producers (master) and the PC owner (slave).
interface pc_fetch_ctrl_if;

  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        redir_pending;
  logic        addr_err;

  modport master (
    output stall, redir_valid, redir_target,
    input  pc, pc4, redir_pending, addr_err
  );

  modport slave (
    input  stall, redir_valid, redir_target,
    output pc, pc4, redir_pending, addr_err
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with a one-entry buffer for redirects that arrive during a stall.
// Optional feature macro: PC_ALIGN_CHECK_EN rejects misaligned targets and flags addr_err.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PKG_RESET_PC,
  parameter int unsigned PC_STEP  = PKG_PC_STEP
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_ctrl_if.slave  fetch_io
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc4_w;
  logic        redir_ok;
  logic [31:0] target_w;

  assign pc4_w = pc_q + 32'(PC_STEP);

`ifdef PC_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;
  logic misaligned_w;

  // A misaligned request is dropped entirely; the cycle proceeds as if no redirect came.
  assign misaligned_w = fetch_io.redir_valid && (fetch_io.redir_target[1:0] != 2'b00);
  assign redir_ok     = fetch_io.redir_valid && !misaligned_w;
  assign target_w     = fetch_io.redir_target;
  assign addr_err_d   = misaligned_w;

  always_ff @(posedge clk) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end

  assign fetch_io.addr_err = addr_err_q;
`else
  assign redir_ok          = fetch_io.redir_valid;
  assign target_w          = word_align(fetch_io.redir_target);
  assign fetch_io.addr_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    case (state_q)
      ST_RUN, ST_HOLD: begin
        if (!fetch_io.stall) begin
          pc_d    = redir_ok ? target_w : pc4_w;
          state_d = ST_RUN;
        end else if (redir_ok) begin
          buf_d   = target_w;
          state_d = ST_HOLD_PEND;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD_PEND: begin
        // While stalled the newest target replaces the buffer; a live request at release wins.
        if (fetch_io.stall) begin
          if (redir_ok) buf_d = target_w;
        end else begin
          pc_d    = redir_ok ? target_w : buf_q;
          buf_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        pc_d    = pc4_w;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  assign fetch_io.pc            = pc_q;
  assign fetch_io.pc4           = pc4_w;
  assign fetch_io.redir_pending = (state_q == ST_HOLD_PEND);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a behavioural PC model pushes expected outputs per cycle.
// Honours PC_ALIGN_CHECK_EN the same way the design does.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pc_fetch_ctrl_if fif ();

  pc_fetch_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_io (fif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        aerr;
  } exp_t;

  exp_t sbQ[$];
  int checkCount = 0;
  int errorCount = 0;

  // Model state: 0 = run, 1 = hold, 2 = hold with buffered target.
  logic [31:0] mPc;
  logic [31:0] mBuf;
  int          mState;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareOne();
    exp_t e;
    checkOutput("sb_depth", 32'(sbQ.size()), 32'd1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    checkOutput("pc", fif.pc, e.pc);
    checkOutput("pc4", fif.pc4, e.pc + 32'd4);
    checkOutput("redir_pending", {31'd0, fif.redir_pending}, {31'd0, e.pend});
    checkOutput("addr_err", {31'd0, fif.addr_err}, {31'd0, e.aerr});
  endtask

  task automatic applyReset();
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    fif.stall = 1'b0;
    fif.redir_valid = 1'b0;
    fif.redir_target = '0;
    mPc = 32'h0000_3000;
    mBuf = '0;
    mState = 0;
    e.pc = mPc; e.pend = 1'b0; e.aerr = 1'b0;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    compareOne();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] tgt);
    exp_t e;
    logic acc;
    logic err;
    logic [31:0] t;
    @(negedge clk);
    fif.stall = st;
    fif.redir_valid = rv;
    fif.redir_target = tgt;
`ifdef PC_ALIGN_CHECK_EN
    err = rv && (tgt[1:0] != 2'b00);
    acc = rv && !err;
    t = tgt;
`else
    err = 1'b0;
    acc = rv;
    t = {tgt[31:2], 2'b00};
`endif
    if (mState == 2) begin
      if (st) begin
        if (acc) mBuf = t;
      end else begin
        mPc = acc ? t : mBuf;
        mBuf = '0;
        mState = 0;
      end
    end else if (!st) begin
      mPc = acc ? t : mPc + 32'd4;
      mState = 0;
    end else if (acc) begin
      mBuf = t;
      mState = 2;
    end else begin
      mState = 1;
    end
    e.pc = mPc; e.pend = (mState == 2); e.aerr = err;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    compareOne();
  endtask

  initial begin
    fif.stall = 1'b0;
    fif.redir_valid = 1'b0;
    fif.redir_target = '0;

    applyReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_3100);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Stalled redirect buffered, then released after three quiet stall cycles.
    applyStimulus(1'b1, 1'b1, 32'h0000_3200);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Newest buffered target overwrites, live request at release wins.
    applyStimulus(1'b1, 1'b1, 32'h0000_3200);
    applyStimulus(1'b1, 1'b1, 32'h0000_3300);
    applyStimulus(1'b0, 1'b1, 32'h0000_3400);

    // Overwrite then release without a live request: buffered 0x3300 applies.
    applyStimulus(1'b1, 1'b1, 32'h0000_3200);
    applyStimulus(1'b1, 1'b1, 32'h0000_3300);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // HOLD first, redirect arrives later in the stall.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_3600);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_3700);

    // Reset while a redirect is pending must discard it.
    applyStimulus(1'b1, 1'b1, 32'h0000_3800);
    applyReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Misaligned target, then a quiet cycle so the addr_err pulse width is observed.
    applyStimulus(1'b0, 1'b1, 32'h0000_3102);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_3503);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // pc4 wrap-around at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] tgt;
      tgt = 32'h0000_4000 + (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
